dplinkseq: RTL and testbench
============================

# dplinkseq

Link-level sequencer sitting between the `stuff` transfer-unit packer and the lane scrambler/encoder. It chooses what the two main-link lanes carry: TPS1 or TPS2 training patterns, the DisplayPort idle pattern, or the stuffed video stream. It also holds `stuff`/`pxclk` in reset whenever video is not being transmitted, and gates the scrambler. Both lanes always carry identical control patterns. In video mode each lane carries its own `stuff` output.

## Interface
Parameters:
- `IDLEPER`, 4096: idle-pattern period in clock cycles (2 symbols/cycle, so 8192 link symbols).
- `SRPER`, 512: every `SRPER`-th idle BS is replaced by SR.

Ports:
- `clk`  in  1  link symbol clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tps`  in  2  training request from AUX side: 0 = normal, 1 = TPS1, 2 = TPS2, 3 = treated as TPS2.
- `vidon`  in  1  video stream enable (level).
- `dpdat0`, `dpdat1`  in  16  lane data from `stuff`.
- `dpisk0`, `dpisk1`  in  2  K-flags from `stuff`.
- `ldat0`, `ldat1`  out  16  lane data to scrambler; [7:0] is the first symbol, [15:8] the second.
- `lisk0`, `lisk1`  out  2  per-symbol K-flag; bit 0 pairs with [7:0].
- `scren`  out  1  scrambler enable.
- `stuffrst`  out  1  active-high reset to `stuff` and `pxclk`.
- `training`  out  1  high in TPS1/TPS2 states.

## Operation
- States: `TPS1`, `TPS2`, `IDLE`, `VIDEO`. Reset state is `IDLE`.
- Counters:
  - `pcnt` (0..4): TPS2 phase.
  - `icnt` (0..IDLEPER-1): idle position, wraps.
  - `bscnt` (0..SRPER-1): idle BS count, wraps.
- TPS1 output: every cycle `4A 4A`, K = 00.
- TPS2 output by `pcnt`:
  - 0 and 1: [7:0] = `BC` (K28.5, K=1), [15:8] = `CB` (D11.6), K = 01.
  - 2, 3 and 4: `4A 4A`, K = 00.
- IDLE output by `icnt`:
  - `icnt`==0: [7:0] = `symBS`, or `symSR` when `bscnt`==0; [15:8] = VB-ID `08` (NoVideoStream); K = 01; `bscnt` increments.
  - `icnt`==1: `00 00` (Mvid7:0, Maud7:0), K = 00.
  - All other `icnt`: `00 00`, K = 00.
- VIDEO output: `ldatN`/`liskN` = `dpdatN`/`dpiskN`.
- `scren` = 1 in IDLE and VIDEO, 0 in TPS states.
- `stuffrst` = 0 only in VIDEO.
- `training` = 1 only in TPS1 and TPS2.
- Transitions, in priority order, evaluated every cycle:
  - `tps`==1, from any state other than TPS2: go to TPS1 next cycle.
  - `tps`==1 while in TPS2: go to TPS1 only when `pcnt`==4.
  - `tps`>=2 from IDLE, VIDEO or TPS1: go to TPS2 next cycle with `pcnt`=0.
  - `tps`==0 in TPS1: go to IDLE with `icnt`=0 and `bscnt`=0, so the first emitted BS is an SR.
  - `tps`==0 in TPS2: same as from TPS1, but only when `pcnt`==4.
  - IDLE to VIDEO: `tps`==0, `vidon`==1 and `icnt`==IDLEPER-1.
  - VIDEO to IDLE: `vidon`==0. Next cycle `icnt`=0; `bscnt` is not cleared.
- Counter behaviour:
  - `pcnt` runs only in TPS2.
  - `icnt` runs only in IDLE.
  - Both are cleared when their state is entered.

## Timing
- State, counters and outputs are all registered. The output for a state/counter value appears on the same edge the state register takes that value.
- VIDEO pass-through latency is 1 cycle from `dpdat`/`dpisk` to `ldat`/`lisk`.
- `stuffrst` changes on the same edge the state enters or leaves VIDEO.
- Reset values (asynchronous, while `reset`=0):
  - `ldat0`/`ldat1` = 0, `lisk0`/`lisk1` = 0.
  - `scren` = 0, `stuffrst` = 1, `training` = 0.
  - state = IDLE, `icnt` = `pcnt` = `bscnt` = 0.
- After reset release:
  - First edge with `tps`==0 emits `symSR 08`, K = 01.
  - `scren` rises on that edge.
- Reset asserted mid-pattern or mid-video: immediate return to reset values; no pattern completion.
- `vidon` and a `tps` change in the same cycle: the `tps` transition wins.
- `tps` toggling faster than 5 cycles in TPS2: only the value sampled at `pcnt`==4 is acted on.
- `icnt` wrap: IDLEPER-1 → 0. `bscnt` wrap: SRPER-1 → 0, giving SR once per SRPER BS.

## Test plan
- Reset, `tps`=0, `vidon`=0: first output `symSR`/`08` K=01; next BS at cycle 4096 is `symBS`; SR recurs at cycle 512×4096. `stuffrst`=1 throughout.
- `tps`=1 for 20 cycles: `4A4A` K=00 every cycle, `training`=1, `scren`=0. Then `tps`=2: pattern `BC/CB`, `BC/CB`, `4A4A`×3, repeating with period 5.
- In TPS2, drop `tps` to 0 at `pcnt`==1: TPS2 continues through `pcnt`==4, then IDLE begins with SR.
- IDLE with `vidon`=1 asserted at `icnt`=100: VIDEO entered after `icnt`=4095; `stuffrst` falls on that edge; `ldat0` equals `dpdat0` delayed one cycle.
- In VIDEO, drop `vidon`: next output is BS/`08`, `stuffrst`=1. Separately, `tps`=1 in VIDEO goes directly to TPS1.
- Assert `reset` low during TPS2 `pcnt`=2: outputs go to 0 asynchronously; release resumes in IDLE with SR.

Source files
------------

// File: rtl/dplinkseq.sv
// Main-link sequencer: selects training patterns, idle pattern or stuffed video for both lanes,
// holds the stuffer in reset outside video and gates the scrambler.
module dplinkseq #(
  parameter int unsigned IDLEPER = 4096,
  parameter int unsigned SRPER   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  tps,
  input  logic        vidon,
  input  logic [15:0] dpdat0,
  input  logic [15:0] dpdat1,
  input  logic [1:0]  dpisk0,
  input  logic [1:0]  dpisk1,
  output logic [15:0] ldat0,
  output logic [15:0] ldat1,
  output logic [1:0]  lisk0,
  output logic [1:0]  lisk1,
  output logic        scren,
  output logic        stuffrst,
  output logic        training
);

  localparam int unsigned IW = (IDLEPER > 1) ? $clog2(IDLEPER) : 1;
  localparam int unsigned BW = (SRPER > 1) ? $clog2(SRPER) : 1;

  localparam logic [7:0] SymBs     = 8'hBC;  // K28.5
  localparam logic [7:0] SymSr     = 8'h1C;  // K28.0
  localparam logic [7:0] SymK285   = 8'hBC;
  localparam logic [7:0] SymD116   = 8'hCB;
  localparam logic [7:0] SymD102   = 8'h4A;
  localparam logic [7:0] VbIdNoVid = 8'h08;

  typedef enum logic [1:0] {StTps1, StTps2, StIdle, StVideo} state_e;

  state_e          state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [IW-1:0]   icnt_q, icnt_d;
  logic [BW-1:0]   bscnt_q, bscnt_d, bs_base;
  logic            started_q;
  logic            in_tps, pdone;
  logic [15:0]     ldat0_d, ldat1_d;
  logic [1:0]      lisk0_d, lisk1_d;

  always_comb begin
    state_d = state_q;
    pcnt_d  = 3'd0;
    icnt_d  = icnt_q;
    bscnt_d = bscnt_q;
    bs_base = bscnt_q;
    ldat0_d = '0;
    ldat1_d = '0;
    lisk0_d = '0;
    lisk1_d = '0;

    in_tps = state_q inside {StTps1, StTps2};
    // TPS2 only yields once its 5-cycle pattern has completed
    pdone  = (state_q != StTps2) || (pcnt_q == 3'd4);

    if (tps == 2'd1) begin
      if (pdone) state_d = StTps1;
    end else if (tps[1]) begin
      state_d = StTps2;
    end else if (in_tps && pdone) begin
      state_d = StIdle;
    end else if (state_q == StIdle && vidon && icnt_q == IW'(IDLEPER - 1)) begin
      state_d = StVideo;
    end else if (state_q == StVideo && !vidon) begin
      state_d = StIdle;
    end

    if (state_d == StTps2 && state_q == StTps2) begin
      pcnt_d = (pcnt_q == 3'd4) ? 3'd0 : pcnt_q + 3'd1;
    end

    if (state_d == StIdle) begin
      // Right after reset the idle position 0 has not been emitted yet
      if (state_q == StIdle && started_q) begin
        icnt_d = (icnt_q == IW'(IDLEPER - 1)) ? '0 : icnt_q + IW'(1);
      end else begin
        icnt_d = '0;
      end
      if (in_tps) bs_base = '0;
      if (icnt_d == '0) begin
        bscnt_d = (bs_base == BW'(SRPER - 1)) ? '0 : bs_base + BW'(1);
      end
    end

    unique case (state_d)
      StTps1: begin
        ldat0_d = {SymD102, SymD102};
        ldat1_d = {SymD102, SymD102};
      end
      StTps2: begin
        if (pcnt_d <= 3'd1) begin
          ldat0_d = {SymD116, SymK285};
          ldat1_d = {SymD116, SymK285};
          lisk0_d = 2'b01;
          lisk1_d = 2'b01;
        end else begin
          ldat0_d = {SymD102, SymD102};
          ldat1_d = {SymD102, SymD102};
        end
      end
      StIdle: begin
        if (icnt_d == '0) begin
          ldat0_d = {VbIdNoVid, (bs_base == '0) ? SymSr : SymBs};
          ldat1_d = ldat0_d;
          lisk0_d = 2'b01;
          lisk1_d = 2'b01;
        end
      end
      StVideo: begin
        ldat0_d = dpdat0;
        ldat1_d = dpdat1;
        lisk0_d = dpisk0;
        lisk1_d = dpisk1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pcnt_q    <= 3'd0;
      icnt_q    <= '0;
      bscnt_q   <= '0;
      started_q <= 1'b0;
      ldat0     <= '0;
      ldat1     <= '0;
      lisk0     <= '0;
      lisk1     <= '0;
      scren     <= 1'b0;
      stuffrst  <= 1'b1;
      training  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      icnt_q    <= icnt_d;
      bscnt_q   <= bscnt_d;
      started_q <= 1'b1;
      ldat0     <= ldat0_d;
      ldat1     <= ldat1_d;
      lisk0     <= lisk0_d;
      lisk1     <= lisk1_d;
      scren     <= (state_d == StIdle) || (state_d == StVideo);
      stuffrst  <= (state_d != StVideo);
      training  <= (state_d == StTps1) || (state_d == StTps2);
    end
  end

endmodule

// File: tb/tb_dplinkseq.sv
// Bench for dplinkseq: behavioural link model checked every cycle plus directed literal checks.
module tb_dplinkseq;

  localparam int IDLEPER = 16;
  localparam int SRPER   = 4;

  localparam int M_IDLE  = 0;
  localparam int M_VIDEO = 1;
  localparam int M_TPS1  = 2;
  localparam int M_TPS2  = 3;

  // {ldat0, ldat1, lisk0, lisk1, scren, stuffrst, training}
  localparam logic [38:0] V_RST   = {16'h0000, 16'h0000, 2'b00, 2'b00, 3'b010};
  localparam logic [38:0] V_TPS1  = {16'h4A4A, 16'h4A4A, 2'b00, 2'b00, 3'b011};
  localparam logic [38:0] V_TPS2K = {16'hCBBC, 16'hCBBC, 2'b01, 2'b01, 3'b011};
  localparam logic [38:0] V_SR    = {16'h081C, 16'h081C, 2'b01, 2'b01, 3'b110};
  localparam logic [38:0] V_BS    = {16'h08BC, 16'h08BC, 2'b01, 2'b01, 3'b110};
  localparam logic [38:0] V_IDLE  = {16'h0000, 16'h0000, 2'b00, 2'b00, 3'b110};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  tps = 2'd0;
  logic        vidon = 1'b0;
  logic [15:0] dpdat0 = 16'h0, dpdat1 = 16'h0;
  logic [1:0]  dpisk0 = 2'b0, dpisk1 = 2'b0;
  logic [15:0] ldat0, ldat1;
  logic [1:0]  lisk0, lisk1;
  logic        scren, stuffrst, training;
  logic [38:0] got;
  logic [15:0] prev_d0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dplinkseq #(
    .IDLEPER(IDLEPER),
    .SRPER  (SRPER)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tps     (tps),
    .vidon   (vidon),
    .dpdat0  (dpdat0),
    .dpdat1  (dpdat1),
    .dpisk0  (dpisk0),
    .dpisk1  (dpisk1),
    .ldat0   (ldat0),
    .ldat1   (ldat1),
    .lisk0   (lisk0),
    .lisk1   (lisk1),
    .scren   (scren),
    .stuffrst(stuffrst),
    .training(training)
  );

  assign got = {ldat0, ldat1, lisk0, lisk1, scren, stuffrst, training};

  // ipos is the last emitted idle position (-1: none yet); nbs counts BS since last clear
  typedef struct packed {
    int          mode;
    int          phase;
    int          ipos;
    int          nbs;
    logic [38:0] exp;
  } model_t;

  function automatic model_t reset_model();
    model_t r;
    r.mode  = M_IDLE;
    r.phase = 0;
    r.ipos  = -1;
    r.nbs   = 0;
    r.exp   = V_RST;
    return r;
  endfunction

  function automatic model_t step(model_t m, logic [1:0] t, logic v, logic [15:0] d0,
                                  logic [15:0] d1, logic [1:0] k0, logic [1:0] k1);
    model_t n;
    bit     from_tps;
    n = m;
    from_tps = (m.mode == M_TPS1) || (m.mode == M_TPS2);
    if (m.mode == M_TPS2 && m.phase != 4) n.mode = M_TPS2;
    else if (t == 2'd1)                   n.mode = M_TPS1;
    else if (t >= 2'd2)                   n.mode = M_TPS2;
    else if (from_tps)                    n.mode = M_IDLE;
    else if (m.mode == M_IDLE)            n.mode = (v && m.ipos == IDLEPER - 1) ? M_VIDEO : M_IDLE;
    else                                  n.mode = v ? M_VIDEO : M_IDLE;

    n.phase = (m.mode == M_TPS2 && n.mode == M_TPS2) ? (m.phase + 1) % 5 : 0;
    if (n.mode == M_IDLE) begin
      if (from_tps) n.nbs = 0;
      n.ipos = (m.mode == M_IDLE) ? (m.ipos + 1) % IDLEPER : 0;
    end

    case (n.mode)
      M_TPS1: n.exp = V_TPS1;
      M_TPS2: n.exp = (n.phase < 2) ? V_TPS2K : V_TPS1;
      M_IDLE: begin
        if (n.ipos == 0) begin
          n.exp = (n.nbs % SRPER == 0) ? V_SR : V_BS;
          n.nbs = n.nbs + 1;
        end else begin
          n.exp = V_IDLE;
        end
      end
      default: n.exp = {d0, d1, k0, k1, 3'b100};
    endcase
    return n;
  endfunction

  model_t m;

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= reset_model();
    else        m <= step(m, tps, vidon, dpdat0, dpdat1, dpisk0, dpisk1);
  end

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) chk("model", got, m.exp);

  task automatic tick();
    @(negedge clk);
    prev_d0 = dpdat0;
    dpdat0  = 16'($urandom);
    dpdat1  = 16'($urandom);
    dpisk0  = 2'($urandom);
    dpisk1  = 2'($urandom);
  endtask

  task automatic wait_video(input string name, output int k);
    k = 0;
    while (stuffrst !== 1'b0 && k < 40) begin
      tick();
      k++;
    end
    if (stuffrst !== 1'b0) chk(name, 39'(stuffrst), 39'd0);
  endtask

  initial begin
    int k;
    #1 reset = 1'b0;
    #1 chk("reset_vals", got, V_RST);
    tick();
    tick();
    reset = 1'b1;

    // Idle pattern: SR first, BS every IDLEPER, SR again after SRPER BS
    for (int e = 1; e <= 66; e++) begin
      tick();
      if (e == 1)  chk("first_sr", got, V_SR);
      if (e == 2)  chk("idle_fill", got, V_IDLE);
      if (e == 17) chk("second_bs", got, V_BS);
      if (e == 65) chk("sr_recur", got, V_SR);
    end

    tps = 2'd1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("tps1", got, V_TPS1);
    end

    tps = 2'd2;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("tps2_pat", got, (i % 5 < 2) ? V_TPS2K : V_TPS1);
    end

    // Dropped at pcnt==1: pattern completes before idle
    tps = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tps2_tail", got, V_TPS1);
    end
    tick();
    chk("tps2_exit_sr", got, V_SR);

    for (int i = 0; i < 5; i++) tick();
    vidon = 1'b1;
    wait_video("video_timeout", k);
    chk("video_entry", 39'(k), 39'd11);
    chk("video_pass0", 39'(ldat0), 39'(prev_d0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("video_pass", 39'(ldat0), 39'(prev_d0));
    end

    vidon = 1'b0;
    tick();
    chk("video_exit_bs", got, V_BS);

    vidon = 1'b1;
    wait_video("video_timeout2", k);
    tps = 2'd1;
    tick();
    chk("video_to_tps1", got, V_TPS1);

    // Reset mid-TPS2 at pcnt==2
    tps = 2'd2;
    tick();
    tick();
    tick();
    chk("tps2_p2", got, V_TPS1);
    #2 reset = 1'b0;
    #1 chk("async_reset", got, V_RST);
    tps   = 2'd0;
    vidon = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_sr", got, V_SR);

    // tps toggling in TPS2: only the value at pcnt==4 counts
    tps = 2'd2;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      tps = (i % 2 == 1) ? 2'd1 : 2'd0;
      tick();
      if (i == 2) chk("toggle_p4", got, V_TPS1);
      if (i == 3) chk("toggle_to_tps1", {got[38:3], training}, {V_TPS1[38:3], 1'b1});
    end
    tps = 2'd0;
    for (int i = 0; i < 5; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
